// File: rtl/mt_cpu_pkg.sv
// Shared types and constants for the barrel-threaded CPU and its program loader.
package mt_cpu_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; flags the word on its 4th byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane  <= 2'd0;
            shreg <= 24'd0;
        end else if (clear) begin
            lane  <= 2'd0;
            shreg <= 24'd0;
        end else if (byte_valid) begin
            lane  <= lane + 2'd1;
            shreg <= {byte_data, shreg[23:8]};
        end
    end

    // The 4th byte completes the word in the same cycle it arrives.
    assign word_valid = byte_valid && (lane == 2'd3);
    assign word       = {byte_data, shreg};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import mt_cpu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int IMEM_SIZE     = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     reload,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic                     cpu_rst,
    output logic                     done,
    output logic                     error,
    output logic [15:0]              words_loaded
);

    localparam logic [15:0] MAX_WORDS = 16'(IMEM_SIZE);

    loader_state_t state;
    logic [7:0]    count_lo;
    logic [15:0]   n_words;
    logic [15:0]   hdr_count;
    logic          accept;
    logic          restart;
    logic          word_valid;
    logic [31:0]   word;
    logic          chk_match;

    // NOTE: in_ready is decoded straight from the state register, so a byte can be taken
    // on the very cycle HDR_LO is re-entered; it is the only unregistered output.
    assign in_ready  = (state == HDR_LO) || (state == HDR_HI) || (state == DATA) || (state == CHK);
    assign accept    = in_valid && in_ready;
    assign restart   = reload && ((state == DONE) || (state == ERROR));
    assign hdr_count = {in_data, count_lo};

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
    logic [7:0] chk_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_acc <= 8'd0;
        end else if (restart) begin
            chk_acc <= 8'd0;
        end else if (accept && (state != CHK)) begin
            chk_acc <= chk_acc ^ in_data;
        end
    end

    assign chk_match = (chk_acc == in_data);
`else
    localparam bit CHK_EN = 1'b0;
    assign chk_match = 1'b0;
`endif

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HDR_LO;
            count_lo     <= 8'd0;
            n_words      <= 16'd0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR_LO: if (accept) begin
                    count_lo <= in_data;
                    state    <= HDR_HI;
                end
                HDR_HI: if (accept) begin
                    n_words <= hdr_count;
                    if (hdr_count > MAX_WORDS) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end else if (hdr_count != 16'd0) begin
                        state <= DATA;
                    end else if (CHK_EN) begin
                        state <= CHK;
                    end else begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end
                end
                DATA: if (word_valid) begin
                    imem_we      <= 1'b1;
                    imem_addr    <= ADDRESS_WIDTH'(words_loaded) * ADDRESS_WIDTH'(WORD_BYTES);
                    imem_wdata   <= word;
                    words_loaded <= words_loaded + 16'd1;
                    if (words_loaded + 16'd1 == n_words) begin
                        if (CHK_EN) begin
                            state <= CHK;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end
                    end
                end
                CHK: if (accept) begin
                    if (chk_match) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                end
                DONE, ERROR: if (reload) begin
                    state        <= HDR_LO;
                    words_loaded <= 16'd0;
                    cpu_rst      <= 1'b1;
                    done         <= 1'b0;
                    error        <= 1'b0;
                end
                default: state <= HDR_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized frames against a frame-level reference model.
module tb_imem_loader;

    localparam int IMEM_SIZE = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  frame[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    imem_loader #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .IMEM_SIZE     (IMEM_SIZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every write strobe away from the active edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_frame(input int n, input bit good_chk);
        logic [7:0] x;
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        if (n <= IMEM_SIZE) begin
            for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom_range(0, 255)));
            if (CHK_EN) begin
                x = 8'h00;
                foreach (frame[i]) x ^= frame[i];
                frame.push_back(good_chk ? x : (x ^ 8'($urandom_range(1, 255))));
            end
        end
    endtask

    task automatic send_frame(input bit gaps, input bit rand_reload);
        int guard;
        foreach (frame[k]) begin
            if (gaps) begin
                in_valid = 1'b0;
                reload   = rand_reload ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
                reload = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = frame[k];
            guard    = 0;
            while (in_ready !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout byte=%0d in_ready=%b required=1", k, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Frame-level model: header count, little-endian words, XOR over the whole frame.
    task automatic check_result(input string tag);
        int          n;
        bit          exp_err;
        int          exp_writes;
        logic [7:0]  x;
        logic [31:0] w;
        repeat (2) tick();
        n          = int'({frame[1], frame[0]});
        exp_err    = (n > IMEM_SIZE);
        exp_writes = exp_err ? 0 : n;
        if (!exp_err && CHK_EN) begin
            x = 8'h00;
            foreach (frame[i]) x ^= frame[i];
            exp_err = (x != 8'h00);
        end
        vectors++;
        if (done !== !exp_err) begin
            miscompares++;
            $display("FAIL %s_done got=%b exp=%b", tag, done, !exp_err);
        end
        vectors++;
        if (error !== exp_err) begin
            miscompares++;
            $display("FAIL %s_error got=%b exp=%b", tag, error, exp_err);
        end
        vectors++;
        if (cpu_rst !== exp_err) begin
            miscompares++;
            $display("FAIL %s_cpu_rst got=%b exp=%b", tag, cpu_rst, exp_err);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_in_ready got=%b exp=0", tag, in_ready);
        end
        vectors++;
        if (words_loaded !== 16'(exp_writes)) begin
            miscompares++;
            $display("FAIL %s_words_loaded got=%0d exp=%0d", tag, words_loaded, exp_writes);
        end
        vectors++;
        if (got_addr.size() != exp_writes) begin
            miscompares++;
            $display("FAIL %s_write_count got=%0d exp=%0d", tag, got_addr.size(), exp_writes);
        end
        for (int i = 0; i < exp_writes && i < got_addr.size(); i++) begin
            w = {frame[2 + 4*i + 3], frame[2 + 4*i + 2], frame[2 + 4*i + 1], frame[2 + 4*i]};
            vectors++;
            if (got_addr[i] !== 32'(4 * i) || got_data[i] !== w) begin
                miscompares++;
                $display("FAIL %s_write%0d got=%h:%h exp=%h:%h", tag, i, got_addr[i], got_data[i], 32'(4 * i), w);
            end
        end
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        vectors++;
        if (cpu_rst !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0) begin
            miscompares++;
            $display("FAIL %s_reload got cpu_rst=%b in_ready=%b done=%b error=%b wl=%0d exp 1 1 0 0 0",
                     tag, cpu_rst, in_ready, done, error, words_loaded);
        end
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic build_basic();
        logic [7:0] x;
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        if (CHK_EN) begin
            x = 8'h00;
            foreach (frame[i]) x ^= frame[i];
            frame.push_back(x);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) tick();
        vectors++;
        if (cpu_rst !== 1'b1 || in_ready !== 1'b1 || imem_we !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
            imem_addr !== 32'd0 || imem_wdata !== 32'd0 || words_loaded !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_values got cpu_rst=%b in_ready=%b we=%b done=%b error=%b addr=%h wdata=%h wl=%0d",
                     cpu_rst, in_ready, imem_we, done, error, imem_addr, imem_wdata, words_loaded);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        got_addr.delete();
        got_data.delete();
        build_basic();
        send_frame(1'b0, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        vectors++;
        if (imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h00100093 ||
            done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 16'd2) begin
            miscompares++;
            $display("FAIL basic_last_cycle got we=%b addr=%h wdata=%h done=%b cpu_rst=%b wl=%0d exp 1 4 00100093 1 0 2",
                     imem_we, imem_addr, imem_wdata, done, cpu_rst, words_loaded);
        end
`endif
        check_result("basic");
    endtask

    task automatic test_done_ignores_input();
        int n_before;
        n_before = got_addr.size();
        in_valid = 1'b1;
        repeat (4) begin
            in_data = 8'($urandom_range(0, 255));
            tick();
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (done !== 1'b1 || words_loaded !== 16'd2 || got_addr.size() != n_before) begin
            miscompares++;
            $display("FAIL done_ignores_input got done=%b wl=%0d writes=%0d exp 1 2 %0d",
                     done, words_loaded, got_addr.size(), n_before);
        end
        do_reload("after_basic");
    endtask

    task automatic test_oversize();
        frame = '{8'h01, 8'h04};
        send_frame(1'b0, 1'b0);
        vectors++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL oversize_hdr got error=%b cpu_rst=%b in_ready=%b we=%b done=%b exp 1 1 0 0 0",
                     error, cpu_rst, in_ready, imem_we, done);
        end
        check_result("oversize");
        do_reload("after_oversize");
    endtask

    task automatic test_gaps();
        build_basic();
        send_frame(1'b1, 1'b0);
        check_result("gaps");
        do_reload("after_gaps");
    endtask

    task automatic test_boundary();
        build_frame(0, 1'b1);
        send_frame(1'b0, 1'b0);
        check_result("n_zero");
        do_reload("after_n_zero");
        build_frame(IMEM_SIZE, 1'b1);
        send_frame(1'b0, 1'b0);
        check_result("n_max");
        do_reload("after_n_max");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        frame = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_frame(1'b0, 1'b0);
        check_result("chk_good");
        do_reload("after_chk_good");
        frame = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_frame(1'b0, 1'b0);
        check_result("chk_bad");
        do_reload("after_chk_bad");
    endtask
`endif

    task automatic test_rst_midframe();
        frame = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        send_frame(1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (cpu_rst !== 1'b1 || in_ready !== 1'b1 || imem_we !== 1'b0 || words_loaded !== 16'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async got cpu_rst=%b in_ready=%b we=%b wl=%0d done=%b exp 1 1 0 0 0",
                     cpu_rst, in_ready, imem_we, words_loaded, done);
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if (got_addr.size() != 0) begin
            miscompares++;
            $display("FAIL rst_no_write got=%0d writes exp=0", got_addr.size());
        end
        build_frame(3, 1'b1);
        send_frame(1'b0, 1'b0);
        check_result("post_rst");
        do_reload("post_rst");
        build_frame(2, 1'b1);
        send_frame(1'b1, 1'b0);
        check_result("post_reload");
        do_reload("post_reload");
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 3))
                0:       n = IMEM_SIZE + 1 + int'($urandom_range(0, 60000));
                1:       n = int'($urandom_range(0, 2));
                default: n = int'($urandom_range(3, 9));
            endcase
            build_frame(n, 1'($urandom_range(0, 3) != 0));
            send_frame(1'($urandom_range(0, 1)), 1'b1);
            check_result($sformatf("rand%0d", t));
            do_reload($sformatf("rand%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_ignores_input();
        test_oversize();
        test_gaps();
        test_boundary();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_rst_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
